// File: rtl/systolic_pkg.sv
// Shared types and defaults for the 2x2 systolic array and its feeder.
package systolic_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned ACC_W_DEF  = 18;
   localparam int unsigned SKEW_STEPS = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FEED0,
      ST_FEED1,
      ST_FEED2,
      ST_DRAIN,
      ST_RESULT
   } feeder_state_t;

endpackage

// File: rtl/matmul2x2_ref.sv
// Combinational signed 2x2 matrix product, used as a reference for the array.
module matmul2x2_ref
   import systolic_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ACC_W  = ACC_W_DEF
) (
   input  logic signed [DATA_W-1:0] a11,
   input  logic signed [DATA_W-1:0] a12,
   input  logic signed [DATA_W-1:0] a21,
   input  logic signed [DATA_W-1:0] a22,
   input  logic signed [DATA_W-1:0] b11,
   input  logic signed [DATA_W-1:0] b12,
   input  logic signed [DATA_W-1:0] b21,
   input  logic signed [DATA_W-1:0] b22,
   output logic signed [ACC_W-1:0]  c11,
   output logic signed [ACC_W-1:0]  c12,
   output logic signed [ACC_W-1:0]  c21,
   output logic signed [ACC_W-1:0]  c22
);

   localparam int unsigned PROD_W = 2 * DATA_W;

   logic signed [PROD_W-1:0] p11a, p11b, p12a, p12b, p21a, p21b, p22a, p22b;

   // Full-width partial products, then sign-extended sums.
   always_comb begin
      p11a = a11 * b11;
      p11b = a12 * b21;
      p12a = a11 * b12;
      p12b = a12 * b22;
      p21a = a21 * b11;
      p21b = a22 * b21;
      p22a = a21 * b12;
      p22b = a22 * b22;
      c11  = ACC_W'(p11a) + ACC_W'(p11b);
      c12  = ACC_W'(p12a) + ACC_W'(p12b);
      c21  = ACC_W'(p21a) + ACC_W'(p21b);
      c22  = ACC_W'(p22a) + ACC_W'(p22b);
   end

endmodule

// File: rtl/systolic_feeder.sv
// Operand sequencer / result collector for the 2x2 systolic array.
// Optional self-check of captured results: define SYSTOLIC_FEEDER_CHECK_EN.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned ACC_W        = ACC_W_DEF,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] a11,
   input  logic signed [DATA_W-1:0] a12,
   input  logic signed [DATA_W-1:0] a21,
   input  logic signed [DATA_W-1:0] a22,
   input  logic signed [DATA_W-1:0] b11,
   input  logic signed [DATA_W-1:0] b12,
   input  logic signed [DATA_W-1:0] b21,
   input  logic signed [DATA_W-1:0] b22,
   output logic                     clear,
   output logic signed [DATA_W-1:0] a1,
   output logic signed [DATA_W-1:0] a2,
   output logic signed [DATA_W-1:0] b1,
   output logic signed [DATA_W-1:0] b2,
   input  logic signed [ACC_W-1:0]  c11,
   input  logic signed [ACC_W-1:0]  c12,
   input  logic signed [ACC_W-1:0]  c21,
   input  logic signed [ACC_W-1:0]  c22,
`ifdef SYSTOLIC_FEEDER_CHECK_EN
   output logic                     mismatch,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  r11,
   output logic signed [ACC_W-1:0]  r12,
   output logic signed [ACC_W-1:0]  r21,
   output logic signed [ACC_W-1:0]  r22
);

   localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   feeder_state_t state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic accept;
   logic capture;

   logic signed [DATA_W-1:0] a11_q, a12_q, a21_q, a22_q;
   logic signed [DATA_W-1:0] b11_q, b12_q, b21_q, b22_q;

   logic in_ready_nxt, clear_nxt, out_valid_nxt;
   logic signed [DATA_W-1:0] a1_nxt, a2_nxt, b1_nxt, b2_nxt;

   // State and drain-counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state plus next values of the registered outputs (decoded from next state).
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      accept        = 1'b0;
      capture       = 1'b0;
      a1_nxt        = '0;
      a2_nxt        = '0;
      b1_nxt        = '0;
      b2_nxt        = '0;

      case (state)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               accept    = 1'b1;
               state_nxt = ST_CLEAR;
            end
         end
         ST_CLEAR: state_nxt = ST_FEED0;
         ST_FEED0: state_nxt = ST_FEED1;
         ST_FEED1: state_nxt = ST_FEED2;
         ST_FEED2: begin
            state_nxt = ST_DRAIN;
            cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
         end
         ST_DRAIN: begin
            if (cnt == '0) begin
               capture   = 1'b1;
               state_nxt = ST_RESULT;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_RESULT: begin
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase

      case (state_nxt)
         ST_FEED0: begin
            a1_nxt = a11_q;
            b1_nxt = b11_q;
         end
         ST_FEED1: begin
            a1_nxt = a12_q;
            b1_nxt = b21_q;
            a2_nxt = a21_q;
            b2_nxt = b12_q;
         end
         ST_FEED2: begin
            a2_nxt = a22_q;
            b2_nxt = b22_q;
         end
         default: ;
      endcase

      in_ready_nxt  = (state_nxt == ST_IDLE);
      clear_nxt     = (state_nxt == ST_CLEAR);
      out_valid_nxt = (state_nxt == ST_RESULT);
   end

   // Registered outputs, operand latch on acceptance and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready  <= 1'b1;
         clear     <= 1'b0;
         out_valid <= 1'b0;
         a1        <= '0;
         a2        <= '0;
         b1        <= '0;
         b2        <= '0;
         r11       <= '0;
         r12       <= '0;
         r21       <= '0;
         r22       <= '0;
         a11_q     <= '0;
         a12_q     <= '0;
         a21_q     <= '0;
         a22_q     <= '0;
         b11_q     <= '0;
         b12_q     <= '0;
         b21_q     <= '0;
         b22_q     <= '0;
      end else begin
         in_ready  <= in_ready_nxt;
         clear     <= clear_nxt;
         out_valid <= out_valid_nxt;
         a1        <= a1_nxt;
         a2        <= a2_nxt;
         b1        <= b1_nxt;
         b2        <= b2_nxt;
         if (accept) begin
            a11_q <= a11;
            a12_q <= a12;
            a21_q <= a21;
            a22_q <= a22;
            b11_q <= b11;
            b12_q <= b12;
            b21_q <= b21;
            b22_q <= b22;
         end
         if (capture) begin
            r11 <= c11;
            r12 <= c12;
            r21 <= c21;
            r22 <= c22;
         end
      end
   end

`ifdef SYSTOLIC_FEEDER_CHECK_EN
   logic signed [ACC_W-1:0] ref11, ref12, ref21, ref22;
   logic mismatch_nxt;

   matmul2x2_ref #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_ref (
      .a11 (a11_q),
      .a12 (a12_q),
      .a21 (a21_q),
      .a22 (a22_q),
      .b11 (b11_q),
      .b12 (b12_q),
      .b21 (b21_q),
      .b22 (b22_q),
      .c11 (ref11),
      .c12 (ref12),
      .c21 (ref21),
      .c22 (ref22)
   );

   // Compare at capture, hold with the result, drop on the output handshake.
   always_comb begin
      mismatch_nxt = mismatch;
      if (capture) begin
         mismatch_nxt = (c11 != ref11) || (c12 != ref12) ||
                        (c21 != ref21) || (c22 != ref22);
      end else if (state == ST_RESULT && out_ready) begin
         mismatch_nxt = 1'b0;
      end
   end

   // Mismatch flag register.
   always_ff @(posedge clk) begin
      if (rst) mismatch <= 1'b0;
      else     mismatch <= mismatch_nxt;
   end
`endif

endmodule
